// File: rtl/bias_accum_relu_pkg.sv
// Shared definitions for the bias/accumulate/ReLU post-processing stage:
// default widths, saturation bounds, FSM state type and lane packing helper.
package bias_accum_relu_pkg;

  localparam int N_LANES_DEF = 16;
  localparam int DATA_W_DEF  = 18;
  localparam int ACC_W_DEF   = 26;

  localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

  typedef enum logic {
    ST_FIRST,
    ST_ACCUM
  } acc_state_e;

  // Lowest bit index of a lane inside a packed multi-lane bus.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/bias_lane_sat.sv
// One lane of the output path: add bias to the accumulated sum, optional
// ReLU, then saturate to DATA_W signed and flag any clipping.
module bias_lane_sat
  import bias_accum_relu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter bit RELU_EN = 1'b1
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  input  logic signed [DATA_W-1:0] i_bias,
  output logic [DATA_W-1:0]        o_res,
  output logic                     o_clip
);

  localparam int SUM_W = ACC_W + 1;

  logic [SUM_W-1:0] w_sum;
  logic             w_neg;
  logic             w_ovf;

  assign w_sum = {i_acc[ACC_W-1], i_acc} + {{(SUM_W-DATA_W){i_bias[DATA_W-1]}}, i_bias};
  assign w_neg = w_sum[SUM_W-1];

  // The sum fits in DATA_W only when all bits above its sign bit repeat it.
  assign w_ovf = (w_sum[SUM_W-1:DATA_W-1] != {(SUM_W-DATA_W+1){w_sum[DATA_W-1]}});

  always_comb begin
    o_res  = w_sum[DATA_W-1:0];
    o_clip = 1'b0;
    if (RELU_EN && w_neg) begin
      o_res = '0;
    end else if (w_ovf) begin
      o_clip = 1'b1;
      o_res  = w_neg ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/bias_accum_relu.sv
// Per-lane accumulator over partial-sum beats of one pixel; on the last beat
// the biased, ReLU'd, saturated pixel is registered behind a valid/ready port.
module bias_accum_relu
  import bias_accum_relu_pkg::*;
#(
  parameter int N_adder_tree = N_LANES_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ACC_W        = ACC_W_DEF,
  parameter bit RELU_EN      = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [N_adder_tree*DATA_W-1:0] in_data,
  input  logic [N_adder_tree*DATA_W-1:0] bias,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_adder_tree*DATA_W-1:0] out_data,
  output logic                           sat_flag,
  output logic [15:0]                    pix_count
);

  localparam int BUS_W = N_adder_tree * DATA_W;

  acc_state_e              r_state;
  acc_state_e              w_state_next;
  logic signed [ACC_W-1:0] r_acc      [N_adder_tree];
  logic signed [ACC_W-1:0] w_acc_next [N_adder_tree];
  logic [BUS_W-1:0]        w_res;
  logic [BUS_W-1:0]        r_out_data;
  logic [N_adder_tree-1:0] w_clip;
  logic                    r_out_valid;
  logic                    r_sat;
  logic [15:0]             r_pix;
  logic                    w_accept;
  logic                    w_out_hs;
  logic                    w_done;

  // A new beat may enter whenever the result register is empty or draining.
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_out_hs  = r_out_valid && out_ready;
  assign w_done    = w_accept && in_last;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sat_flag  = r_sat;
  assign pix_count = r_pix;

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    logic signed [DATA_W-1:0] w_in;
    logic signed [DATA_W-1:0] w_bias;

    assign w_in   = in_data[lane_lo(i, DATA_W) +: DATA_W];
    assign w_bias = bias[lane_lo(i, DATA_W) +: DATA_W];
    assign w_acc_next[i] = (r_state == ST_FIRST)
                         ? {{(ACC_W-DATA_W){w_in[DATA_W-1]}}, w_in}
                         : r_acc[i] + {{(ACC_W-DATA_W){w_in[DATA_W-1]}}, w_in};

    bias_lane_sat #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .RELU_EN(RELU_EN)
    ) u_sat (
      .i_acc (w_acc_next[i]),
      .i_bias(w_bias),
      .o_res (w_res[lane_lo(i, DATA_W) +: DATA_W]),
      .o_clip(w_clip[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FIRST;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept) w_state_next = in_last ? ST_FIRST : ST_ACCUM;
  end

  // Stale accumulator contents after a last beat are harmless: FIRST reloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_adder_tree; i++) r_acc[i] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < N_adder_tree; i++) r_acc[i] <= w_acc_next[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat       <= 1'b0;
      r_pix       <= '0;
    end else begin
      if (w_done) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
      if (w_done && (|w_clip)) r_sat <= 1'b1;
      if (w_out_hs) r_pix <= r_pix + 16'd1;
    end
  end

endmodule

// File: tb/tb_bias_accum_relu.sv
// Bench for bias_accum_relu: ReLU and linear instances share stimulus; a
// reference model queues expected pixels that are popped when outputs appear.
module tb_bias_accum_relu;
  import bias_accum_relu_pkg::*;

  localparam int N  = 16;
  localparam int DW = 18;
  localparam int W  = N * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_last;
  logic [W-1:0]  in_data;
  logic [W-1:0]  bias;
  logic          out_ready;
  logic          in_ready,  lin_in_ready;
  logic          out_valid, lin_out_valid;
  logic [W-1:0]  out_data,  lin_out_data;
  logic          sat_flag,  lin_sat_flag;
  logic [15:0]   pix_count, lin_pix_count;

  int checks = 0;
  int errors = 0;
  int exp_pix;

  longint       m_acc [N];
  bit           m_first;
  bit           m_sat;
  bit           m_sat_lin;
  logic [W-1:0] q_relu [$];
  logic [W-1:0] q_lin  [$];

  always #5 clk = ~clk;

  bias_accum_relu #(.N_adder_tree(N), .DATA_W(DW), .ACC_W(26), .RELU_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_data(in_data), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat_flag(sat_flag), .pix_count(pix_count)
  );

  bias_accum_relu #(.N_adder_tree(N), .DATA_W(DW), .ACC_W(26), .RELU_EN(1'b0)) dut_lin (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(lin_in_ready), .in_last(in_last),
    .in_data(in_data), .bias(bias), .out_valid(lin_out_valid), .out_ready(out_ready),
    .out_data(lin_out_data), .sat_flag(lin_sat_flag), .pix_count(lin_pix_count)
  );

  function automatic logic [W-1:0] put_lane(input logic [W-1:0] bus, input int lane, input int val);
    logic [DW-1:0] v;
    v = DW'(val);
    bus[lane_lo(lane, DW) +: DW] = v;
    return bus;
  endfunction

  function automatic logic [W-1:0] rand_bus();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r = put_lane(r, i, int'($urandom_range(2000)) - 1000);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_acc[i] = 0;
    m_first   = 1'b1;
    m_sat     = 1'b0;
    m_sat_lin = 1'b0;
    q_relu.delete();
    q_lin.delete();
  endtask

  // Reference behaviour of one accepted beat for both ReLU settings.
  task automatic model_accept(input logic [W-1:0] d, input logic [W-1:0] b, input bit last);
    logic [W-1:0]          er, el;
    logic signed [DW-1:0]  t;
    longint                x, bb, s, hi, lo;
    hi = longint'(SAT_MAX);
    lo = longint'(SAT_MIN);
    er = '0;
    el = '0;
    for (int i = 0; i < N; i++) begin
      t = d[lane_lo(i, DW) +: DW];
      x = t;
      m_acc[i] = m_first ? x : m_acc[i] + x;
      if (last) begin
        t  = b[lane_lo(i, DW) +: DW];
        bb = t;
        s  = m_acc[i] + bb;
        if (s > hi) begin
          el[lane_lo(i, DW) +: DW] = SAT_MAX;
          m_sat_lin = 1'b1;
        end else if (s < lo) begin
          el[lane_lo(i, DW) +: DW] = SAT_MIN;
          m_sat_lin = 1'b1;
        end else begin
          el[lane_lo(i, DW) +: DW] = s[DW-1:0];
        end
        if (s < 0) begin
          er[lane_lo(i, DW) +: DW] = '0;
        end else if (s > hi) begin
          er[lane_lo(i, DW) +: DW] = SAT_MAX;
          m_sat = 1'b1;
        end else begin
          er[lane_lo(i, DW) +: DW] = s[DW-1:0];
        end
      end
    end
    if (last) begin
      q_relu.push_back(er);
      q_lin.push_back(el);
    end
    m_first = last;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    bias      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_pix = 0;
  endtask

  // Present one beat from a negedge and hold it until the DUT can take it.
  task automatic drive_beat(input logic [W-1:0] d, input logic [W-1:0] b, input bit last);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    bias     = b;
    in_last  = last;
    #1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout in_ready=%b required 1", in_ready);
    end
    model_accept(d, b, last);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0)     begin errors++; $display("[TB] FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (sat_flag !== 1'b0)   begin errors++; $display("[TB] FAIL reset_sat_flag got %b want 0", sat_flag); end
    checks++; if (pix_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_pix_count got %0d want 0", pix_count); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single_beat();
    logic [W-1:0] exp;
    out_ready = 1'b1;
    drive_beat(put_lane('0, 0, 1000), put_lane('0, 0, 6504), 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b want 1", out_valid); end
    exp = q_relu.pop_front();
    checks++; if (out_data !== exp) begin errors++; $display("[TB] FAIL single_data got %h want %h", out_data, exp); end
    checks++; if (out_data[DW-1:0] !== 18'd7504) begin errors++; $display("[TB] FAIL single_lane0 got %0d want 7504", out_data[DW-1:0]); end
    exp = q_lin.pop_front();
    checks++; if (lin_out_data !== exp) begin errors++; $display("[TB] FAIL single_lin_data got %h want %h", lin_out_data, exp); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL single_sat got %b want 0", sat_flag); end
    @(posedge clk); #1;
    exp_pix++;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain_valid got %b want 0", out_valid); end
    checks++; if (pix_count !== 16'(exp_pix)) begin errors++; $display("[TB] FAIL single_pix got %0d want %0d", pix_count, exp_pix); end
  endtask

  task automatic test_multi_beat();
    logic [W-1:0] b, exp;
    b = put_lane(rand_bus(), 3, -2300);
    drive_beat(put_lane(rand_bus(), 3, 500), b, 1'b0);
    @(negedge clk);
    in_last = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_last_valid got %b want 0", out_valid); end
    in_last = 1'b0;
    drive_beat(put_lane(rand_bus(), 3, -1200), b, 1'b0);
    drive_beat(put_lane(rand_bus(), 3, 300), b, 1'b1);
    exp = q_relu.pop_front();
    checks++; if (out_data !== exp) begin errors++; $display("[TB] FAIL multi_data got %h want %h", out_data, exp); end
    checks++; if (out_data[3*DW +: DW] !== 18'd0) begin errors++; $display("[TB] FAIL multi_relu_lane3 got %h want 0", out_data[3*DW +: DW]); end
    exp = q_lin.pop_front();
    checks++; if (lin_out_data !== exp) begin errors++; $display("[TB] FAIL multi_lin_data got %h want %h", lin_out_data, exp); end
    checks++; if (lin_out_data[3*DW +: DW] !== 18'h3F574) begin errors++; $display("[TB] FAIL multi_lin_lane3 got %h want 3f574", lin_out_data[3*DW +: DW]); end
    @(posedge clk); #1;
    exp_pix++;
    checks++; if (pix_count !== 16'(exp_pix)) begin errors++; $display("[TB] FAIL multi_pix got %0d want %0d", pix_count, exp_pix); end
  endtask

  task automatic test_saturation();
    logic [W-1:0] exp;
    for (int k = 0; k < 4; k++) drive_beat(put_lane('0, 0, 131071), put_lane('0, 0, 6504), k == 3);
    exp = q_relu.pop_front();
    checks++; if (out_data !== exp) begin errors++; $display("[TB] FAIL sat_data got %h want %h", out_data, exp); end
    checks++; if (out_data[DW-1:0] !== 18'h1FFFF) begin errors++; $display("[TB] FAIL sat_lane0 got %h want 1ffff", out_data[DW-1:0]); end
    exp = q_lin.pop_front();
    checks++; if (lin_out_data !== exp) begin errors++; $display("[TB] FAIL sat_lin_data got %h want %h", lin_out_data, exp); end
    checks++; if (sat_flag !== m_sat) begin errors++; $display("[TB] FAIL sat_flag got %b want %b", sat_flag, m_sat); end
    checks++; if (lin_sat_flag !== m_sat_lin) begin errors++; $display("[TB] FAIL sat_lin_flag got %b want %b", lin_sat_flag, m_sat_lin); end
    exp_pix++;
    drive_beat(put_lane('0, 0, 5), put_lane('0, 0, 6504), 1'b1);
    exp = q_relu.pop_front();
    void'(q_lin.pop_front());
    checks++; if (out_data !== exp) begin errors++; $display("[TB] FAIL clean_data got %h want %h", out_data, exp); end
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("[TB] FAIL sat_sticky got %b want 1", sat_flag); end
    @(posedge clk); #1;
    exp_pix++;
    checks++; if (pix_count !== 16'(exp_pix)) begin errors++; $display("[TB] FAIL sat_pix got %0d want %0d", pix_count, exp_pix); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] b, dB, expA, exp;
    b  = rand_bus();
    dB = rand_bus();
    out_ready = 1'b0;
    drive_beat(rand_bus(), b, 1'b1);
    expA = q_relu[0];
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = dB;
    bias     = b;
    in_last  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready cyc %0d got %b want 0", k, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== expA) begin errors++; $display("[TB] FAIL bp_hold cyc %0d got %b/%h want 1/%h", k, out_valid, out_data, expA); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got %b want 1", in_ready); end
    model_accept(dB, b, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_pix++;
    void'(q_relu.pop_front());
    void'(q_lin.pop_front());
    exp = q_relu.pop_front();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL swap_valid got %b want 1", out_valid); end
    checks++; if (out_data !== exp) begin errors++; $display("[TB] FAIL swap_data got %h want %h", out_data, exp); end
    exp = q_lin.pop_front();
    checks++; if (lin_out_data !== exp) begin errors++; $display("[TB] FAIL swap_lin_data got %h want %h", lin_out_data, exp); end
    checks++; if (pix_count !== 16'(exp_pix)) begin errors++; $display("[TB] FAIL swap_pix got %0d want %0d", pix_count, exp_pix); end
    @(posedge clk); #1;
    exp_pix++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      drive_beat(rand_bus(), rand_bus(), 1'b1);
      exp = q_relu.pop_front();
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin errors++; $display("[TB] FAIL b2b_data %0d got %b/%h want 1/%h", k, out_valid, out_data, exp); end
      exp = q_lin.pop_front();
      checks++; if (lin_out_data !== exp) begin errors++; $display("[TB] FAIL b2b_lin_data %0d got %h want %h", k, lin_out_data, exp); end
      checks++; if (pix_count !== 16'(k)) begin errors++; $display("[TB] FAIL b2b_pix %0d got %0d want %0d", k, pix_count, k); end
    end
    @(posedge clk); #1;
    checks++; if (pix_count !== 16'd20) begin errors++; $display("[TB] FAIL b2b_total got %0d want 20", pix_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_pixel();
    logic [W-1:0] exp;
    out_ready = 1'b1;
    drive_beat(put_lane('0, 0, 70000), '0, 1'b0);
    drive_beat(put_lane('0, 0, 50000), '0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b want 0", out_valid); end
    checks++; if (pix_count !== 16'd0) begin errors++; $display("[TB] FAIL midrst_pix got %0d want 0", pix_count); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive_beat(put_lane('0, 0, 10), '0, 1'b1);
    exp = q_relu.pop_front();
    void'(q_lin.pop_front());
    checks++; if (out_data !== exp) begin errors++; $display("[TB] FAIL midrst_data got %h want %h", out_data, exp); end
    checks++; if (out_data[DW-1:0] !== 18'd10) begin errors++; $display("[TB] FAIL midrst_lane0 got %0d want 10", out_data[DW-1:0]); end
    @(posedge clk); #1;
    checks++; if (pix_count !== 16'd1) begin errors++; $display("[TB] FAIL midrst_pix_after got %0d want 1", pix_count); end
  endtask

  task automatic test_pix_wrap();
    logic [W-1:0] exp;
    reset_dut();
    @(negedge clk);
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = '0;
    bias     = '0;
    repeat (65535) @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk); #1;
    checks++; if (pix_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_preload got %h want ffff", pix_count); end
    drive_beat(put_lane('0, 5, 77), '0, 1'b1);
    exp = q_relu.pop_front();
    void'(q_lin.pop_front());
    checks++; if (out_data !== exp) begin errors++; $display("[TB] FAIL wrap_data got %h want %h", out_data, exp); end
    @(posedge clk); #1;
    checks++; if (pix_count !== 16'd0) begin errors++; $display("[TB] FAIL wrap_pix got %h want 0", pix_count); end
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_pixel();
    test_pix_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
